hazard_fwd_unit: RTL and testbench

Hazard detection and forwarding-select generator for the 5-stage pipelined CPU. It keeps a shadow of the EX, MEM and WB pipeline slots: destination register, write-enable, load flag and source registers. From that shadow it drives the 2-bit select of the EX-stage operand MUX2 instances, the load-use stall, and the branch flush. It sits directly upstream of the forwarding muxes and alongside the IF/ID and ID/EX segment registers, which obey its stall and flush outputs.

---
 rtl/hazard_fwd_unit.sv | 119 +++++++++++
 tb/tb_hazard_fwd_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: hazard detection and forwarding-select generator for the
// 5-stage pipeline. Keeps a shadow of the EX/MEM/WB slots and derives the
// EX operand mux selects, the load-use stall and the branch flush.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/flush counters.
//
// Handshake note: there is no valid/ready pair here. stall and flush are
// combinational commands to the IF/ID and ID/EX registers, valid before the
// rising edge of the cycle in which they are asserted; the upstream stage
// must hold the ID instruction steady while stall=1.
module hazard_fwd_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_rf_we,
  input  logic       id_is_load,
  input  logic       ex_branch_taken,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic       stall,
  output logic       flush
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_count
`endif
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic       is_load;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } slot_t;

  slot_t ex_q, mem_q, wb_q;
  slot_t ex_d;
  logic  load_use;

  // A slot only produces a result worth forwarding if it really writes a
  // non-zero register; x0 writes are architecturally discarded.
  function automatic logic slot_writing(input slot_t s);
    return s.valid && s.we && (s.rd != 5'd0);
  endfunction

  // MEM is the younger producer, so it wins over WB for the same register.
  function automatic logic [1:0] fwd_select(input slot_t ex_s,
                                            input logic [4:0] src,
                                            input slot_t mem_s,
                                            input slot_t wb_s);
    logic [1:0] sel;
    sel = 2'd0;
    if (ex_s.valid && (src != 5'd0)) begin
      if (slot_writing(mem_s) && (mem_s.rd == src))
        sel = 2'd1;
      else if (slot_writing(wb_s) && (wb_s.rd == src))
        sel = 2'd2;
    end
    return sel;
  endfunction

  // Hazard outputs and the value the EX slot takes on the next edge.
  always_comb begin
    load_use = id_valid && slot_writing(ex_q) && ex_q.is_load &&
               ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));
    flush    = ex_branch_taken && !rst;
    stall    = load_use && !flush && !rst;
    fwd_a_sel = fwd_select(ex_q, ex_q.rs1, mem_q, wb_q);
    fwd_b_sel = fwd_select(ex_q, ex_q.rs2, mem_q, wb_q);

    ex_d = '0;
    if (!flush && !stall) begin
      ex_d.valid   = id_valid;
      ex_d.rd      = id_rd;
      ex_d.we      = id_rf_we;
      ex_d.is_load = id_is_load;
      ex_d.rs1     = id_rs1;
      ex_d.rs2     = id_rs2;
    end
  end

  // Shadow pipeline advance; reset empties every slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  // Saturating event counters for stall cycles and flush cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall && (perf_stall_q != 32'hFFFF_FFFF))
        perf_stall_q <= perf_stall_q + 32'd1;
      if (flush && (perf_flush_q != 32'hFFFF_FFFF))
        perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flush_count  = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit. Inputs are driven just after the
// falling edge; combinational outputs are sampled 1 time unit later, well
// away from the rising edge.
module tb_hazard_fwd_unit;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_rf_we, id_is_load, ex_branch_taken;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall, flush;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_flush_count;
`endif

  int errors = 0;
  int checks = 0;

  hazard_fwd_unit dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rd           (id_rd),
    .id_rf_we        (id_rf_we),
    .id_is_load      (id_is_load),
    .ex_branch_taken (ex_branch_taken),
    .fwd_a_sel       (fwd_a_sel),
    .fwd_b_sel       (fwd_b_sel),
    .stall           (stall),
    .flush           (flush)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_count  (perf_flush_count)
`endif
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparison point: counts every check, reports and counts failures.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and present one ID-stage instruction.
  task automatic drive(input logic v, input logic [4:0] rd, input logic we,
                       input logic ld, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic br);
    @(negedge clk);
    id_valid        = v;
    id_rd           = rd;
    id_rf_we        = we;
    id_is_load      = ld;
    id_rs1          = rs1;
    id_rs2          = rs2;
    ex_branch_taken = br;
    #1;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    id_valid = 1'b0; id_rd = '0; id_rf_we = 1'b0; id_is_load = 1'b0;
    id_rs1 = '0; id_rs2 = '0; ex_branch_taken = 1'b0;

    // ---- Reset: flush and stall suppressed while rst is high
    drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1);
    drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1);
    chk("rst_flush", flush, 0);
    chk("rst_stall", stall, 0);
    rst = 1'b0;
    nop();
    chk("idle_fwd_a", fwd_a_sel, 0);
    chk("idle_fwd_b", fwd_b_sel, 0);
    chk("idle_stall", stall, 0);
    chk("idle_flush", flush, 0);
`ifdef HAZARD_PERF_CNT_EN
    chk("idle_perf_stall", perf_stall_cycles, 0);
    chk("idle_perf_flush", perf_flush_count, 0);
`endif

    // ---- ALU x5 producer, EX/MEM and MEM/WB forwarding
    drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd1, 5'd2, 1'b0);   // I1: x5 = x1 op x2
    drive(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 5'd0, 1'b0);   // I2: x6 = x5 op x0
    chk("alu_no_stall", stall, 0);
    chk("alu_i1_fwd_a", fwd_a_sel, 0);
    drive(1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 5'd5, 1'b0);   // I3: x8 = x0 op x5
    chk("alu_fwd_a_mem", fwd_a_sel, 1);
    chk("alu_fwd_b_x0", fwd_b_sel, 0);
    nop();
    chk("alu_fwd_a_rs0", fwd_a_sel, 0);
    chk("alu_fwd_b_wb", fwd_b_sel, 2);
    nop(); nop(); nop();

    // ---- Load-use on x7: one stall cycle, then WB forwarding
    drive(1'b1, 5'd7, 1'b1, 1'b1, 5'd1, 5'd0, 1'b0);   // L: x7 = mem[x1]
    chk("ld_issue_stall", stall, 0);
    drive(1'b1, 5'd9, 1'b1, 1'b0, 5'd7, 5'd4, 1'b0);   // C: x9 = x7 op x4
    chk("ld_use_stall", stall, 1);
    chk("ld_use_flush", flush, 0);
    drive(1'b1, 5'd9, 1'b1, 1'b0, 5'd7, 5'd4, 1'b0);   // C held in ID
    chk("ld_stall_one_cycle", stall, 0);
    chk("ld_bubble_fwd_a", fwd_a_sel, 0);
`ifdef HAZARD_PERF_CNT_EN
    chk("ld_perf_stall", perf_stall_cycles, 1);
`endif
    nop();
    chk("ld_fwd_a_wb", fwd_a_sel, 2);
    chk("ld_fwd_b_none", fwd_b_sel, 0);
    chk("ld_after_stall", stall, 0);
    nop(); nop(); nop();

    // ---- x3 written twice back to back: MEM beats WB
    drive(1'b1, 5'd3, 1'b1, 1'b0, 5'd1, 5'd1, 1'b0);
    drive(1'b1, 5'd3, 1'b1, 1'b0, 5'd2, 5'd2, 1'b0);
    drive(1'b1, 5'd10, 1'b1, 1'b0, 5'd3, 5'd3, 1'b0);
    nop();
    chk("prio_fwd_a", fwd_a_sel, 1);
    chk("prio_fwd_b", fwd_b_sel, 1);
    nop(); nop(); nop();

    // ---- x0 never forwards and never stalls
    drive(1'b1, 5'd0, 1'b1, 1'b0, 5'd1, 5'd2, 1'b0);   // write x0
    drive(1'b1, 5'd11, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0);  // read x0, x0
    drive(1'b1, 5'd0, 1'b1, 1'b1, 5'd1, 5'd0, 1'b0);   // load x0
    chk("x0_fwd_a", fwd_a_sel, 0);
    chk("x0_fwd_b", fwd_b_sel, 0);
    drive(1'b1, 5'd12, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0);  // read x0 after load x0
    chk("x0_load_stall", stall, 0);
    nop();
    chk("x0_fwd_a2", fwd_a_sel, 0);
    chk("x0_fwd_b2", fwd_b_sel, 0);
    nop(); nop();

    // ---- Reset mid-operation clears the shadow slots
    drive(1'b1, 5'd14, 1'b1, 1'b1, 5'd1, 5'd0, 1'b0);  // load x14
    rst = 1'b1;
    drive(1'b1, 5'd15, 1'b1, 1'b0, 5'd14, 5'd0, 1'b0); // reader under rst
    chk("rst_mid_stall", stall, 0);
    rst = 1'b0;
    drive(1'b1, 5'd15, 1'b1, 1'b0, 5'd14, 5'd0, 1'b0);
    chk("rst_mid_cleared", stall, 0);
    nop(); nop(); nop();
    rst = 1'b1;
    nop();
    rst = 1'b0;

    // ---- Branch flush coinciding with load-use
    drive(1'b1, 5'd12, 1'b1, 1'b1, 5'd1, 5'd0, 1'b0);  // load x12
    drive(1'b1, 5'd13, 1'b1, 1'b0, 5'd12, 5'd0, 1'b1); // reader + taken branch
    chk("br_flush", flush, 1);
    chk("br_stall", stall, 0);
    nop();
    chk("br_next_flush", flush, 0);
    chk("br_bubble_fwd_a", fwd_a_sel, 0);
    chk("br_bubble_fwd_b", fwd_b_sel, 0);
    chk("br_bubble_stall", stall, 0);
`ifdef HAZARD_PERF_CNT_EN
    chk("br_perf_flush", perf_flush_count, 1);
    chk("br_perf_stall", perf_stall_cycles, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
